// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_timing_pkg : default 640x480@60 timing constants and helpers    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package vga_timing_pkg;

  localparam int CNT_W       = 10;
  localparam int FRAME_CNT_W = 8;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  function automatic logic in_range(input logic [CNT_W-1:0] val,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_ctrl_wrap_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wrap_counter : enabled up-counter wrapping LIMIT -> 0, wrap strobe  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int               WIDTH = CNT_W,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // wrap is qualified by en so it can directly enable a cascaded counter
  assign wrap  = en && (count_q == LIMIT);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_sync_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_sync_ctrl : VGA raster counters with sync/blank/strobe decode   |
// | Option: define VGA_FRAME_CNT_EN to add the frame_cnt output.        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module vga_sync_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic w_h_wrap;
  logic w_v_wrap;

  wrap_counter #(
    .WIDTH (CNT_W),
    .LIMIT (H_LAST)
  ) u_hcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (ena),
    .count (hpos),
    .wrap  (w_h_wrap)
  );

  // vertical counter steps only on the horizontal wrap, so both wrap together
  wrap_counter #(
    .WIDTH (CNT_W),
    .LIMIT (V_LAST)
  ) u_vcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (w_h_wrap),
    .count (vpos),
    .wrap  (w_v_wrap)
  );

  always_comb begin
    hsync       = 1'b1;
    vsync       = 1'b1;
    display_on  = 1'b0;
    line_start  = 1'b0;
    frame_start = 1'b0;
    if (!rst) begin
      hsync       = !in_range(hpos, HS_FIRST, HS_LAST);
      vsync       = !in_range(vpos, VS_FIRST, VS_LAST);
      display_on  = (hpos < H_VIS) && (vpos < V_VIS);
      line_start  = ena && (hpos == '0);
      frame_start = ena && (hpos == '0) && (vpos == '0);
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (w_v_wrap) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  logic w_unused_v_wrap;
  assign w_unused_v_wrap = w_v_wrap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vga_sync_ctrl : directed bench, default timing plus a tiny mode  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_vga_sync_ctrl;

  logic clk = 1'b0;
  logic rst_d, ena_d, rst_s, ena_s;

  logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos;
  logic d_hsync, d_vsync, d_display_on, d_line_start, d_frame_start;
  logic s_hsync, s_vsync, s_display_on, s_line_start, s_frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] d_frame_cnt, s_frame_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // default 640x480 timing
  vga_sync_ctrl u_dut (
    .clk         (clk),
    .rst         (rst_d),
    .ena         (ena_d),
    .hpos        (d_hpos),
    .vpos        (d_vpos),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .display_on  (d_display_on),
    .line_start  (d_line_start),
    .frame_start (d_frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (d_frame_cnt)
`endif
  );

  // tiny timing: 16 pixels x 10 lines, hsync 10..12, vsync 7..8
  vga_sync_ctrl #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) u_small (
    .clk         (clk),
    .rst         (rst_s),
    .ena         (ena_s),
    .hpos        (s_hpos),
    .vpos        (s_vpos),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .display_on  (s_display_on),
    .line_start  (s_line_start),
    .frame_start (s_frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (s_frame_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int n_ls, n_fs, run, n_runs, h, v;
    rst_d = 1'b1; ena_d = 1'b1;
    rst_s = 1'b1; ena_s = 1'b1;
    repeat (3) step();

    check_eq("d_rst_hpos",  32'(d_hpos), 0);
    check_eq("d_rst_vpos",  32'(d_vpos), 0);
    check_eq("d_rst_hsync", 32'(d_hsync), 1);
    check_eq("d_rst_vsync", 32'(d_vsync), 1);
    check_eq("d_rst_disp",  32'(d_display_on), 0);
    check_eq("d_rst_ls",    32'(d_line_start), 0);
    check_eq("d_rst_fs",    32'(d_frame_start), 0);

    rst_d = 1'b0; settle();
    check_eq("d_first_fs",   32'(d_frame_start), 1);
    check_eq("d_first_ls",   32'(d_line_start), 1);
    check_eq("d_first_disp", 32'(d_display_on), 1);

    repeat (639) step();
    check_eq("d_h639",      32'(d_hpos), 639);
    check_eq("d_disp_639",  32'(d_display_on), 1);
    step();
    check_eq("d_disp_640",  32'(d_display_on), 0);
    repeat (15) step();
    check_eq("d_h655",      32'(d_hpos), 655);
    check_eq("d_hs_655",    32'(d_hsync), 1);
    step();
    check_eq("d_hs_656",    32'(d_hsync), 0);
    repeat (95) step();
    check_eq("d_h751",      32'(d_hpos), 751);
    check_eq("d_hs_751",    32'(d_hsync), 0);
    step();
    check_eq("d_hs_752",    32'(d_hsync), 1);
    repeat (47) step();
    check_eq("d_h799",      32'(d_hpos), 799);
    check_eq("d_v799",      32'(d_vpos), 0);
    check_eq("d_ls_799",    32'(d_line_start), 0);
    step();
    check_eq("d_wrap_h",    32'(d_hpos), 0);
    check_eq("d_wrap_v",    32'(d_vpos), 1);
    check_eq("d_wrap_ls",   32'(d_line_start), 1);
    check_eq("d_wrap_fs",   32'(d_frame_start), 0);

    repeat (300) step();
    check_eq("d_mid_h",     32'(d_hpos), 300);
    check_eq("d_mid_disp",  32'(d_display_on), 1);
    rst_d = 1'b1; settle();
    check_eq("d_inrst_disp", 32'(d_display_on), 0);
    step();
    rst_d = 1'b0; ena_d = 1'b0; settle();
    check_eq("d_post_rst_h",  32'(d_hpos), 0);
    check_eq("d_post_rst_v",  32'(d_vpos), 0);
    check_eq("d_noena_ls",    32'(d_line_start), 0);
    check_eq("d_noena_fs",    32'(d_frame_start), 0);
    repeat (5) step();
    check_eq("d_hold_h",      32'(d_hpos), 0);
    ena_d = 1'b1; settle();
    check_eq("d_ena_fs",      32'(d_frame_start), 1);
    step();
    check_eq("d_ena_h1",      32'(d_hpos), 1);
    rst_d = 1'b1;

    check_eq("s_rst_hsync", 32'(s_hsync), 1);
    check_eq("s_rst_fs",    32'(s_frame_start), 0);
    rst_s = 1'b0; settle();
    n_ls = 0; n_fs = 0; run = 0; n_runs = 0;
    for (int i = 0; i < 160; i++) begin
      h = i % 16;
      v = i / 16;
      if (s_line_start)  n_ls++;
      if (s_frame_start) n_fs++;
      if (s_hsync == 1'b0) begin
        run++;
      end else if (run != 0) begin
        check_eq("s_hsync_run", 32'(run), 3);
        n_runs++;
        run = 0;
      end
      if (i == 0)  check_eq("s_disp_00", 32'(s_display_on), 1);
      if (i == 9)  check_eq("s_hs_9",  32'(s_hsync), 1);
      if (i == 10) check_eq("s_hs_10", 32'(s_hsync), 0);
      if (i == 12) check_eq("s_hs_12", 32'(s_hsync), 0);
      if (i == 13) check_eq("s_hs_13", 32'(s_hsync), 1);
      if (i == 5*16+7) check_eq("s_disp_7_5", 32'(s_display_on), 1);
      if (i == 5*16+8) check_eq("s_disp_8_5", 32'(s_display_on), 0);
      if (i == 6*16+7) check_eq("s_disp_7_6", 32'(s_display_on), 0);
      if (h == 0 && v == 6) check_eq("s_vs_6", 32'(s_vsync), 1);
      if (h == 0 && v == 7) check_eq("s_vs_7", 32'(s_vsync), 0);
      if (h == 0 && v == 8) check_eq("s_vs_8", 32'(s_vsync), 0);
      if (h == 0 && v == 9) check_eq("s_vs_9", 32'(s_vsync), 1);
      if (h == 0 && v >= 6) check_eq("s_vpos_line", 32'(s_vpos), 32'(v));
      step();
    end
    check_eq("s_n_line_start",  32'(n_ls), 10);
    check_eq("s_n_frame_start", 32'(n_fs), 1);
    check_eq("s_n_hsync_runs",  32'(n_runs), 10);
    check_eq("s_frame_h",       32'(s_hpos), 0);
    check_eq("s_frame_v",       32'(s_vpos), 0);
`ifdef VGA_FRAME_CNT_EN
    check_eq("s_fcnt_1",        32'(s_frame_cnt), 1);
`endif

    repeat (7*16+11) step();
    check_eq("s_mid_h",   32'(s_hpos), 11);
    check_eq("s_mid_v",   32'(s_vpos), 7);
    check_eq("s_mid_hs",  32'(s_hsync), 0);
    check_eq("s_mid_vs",  32'(s_vsync), 0);
    rst_s = 1'b1; settle();
    check_eq("s_inrst_hs",   32'(s_hsync), 1);
    check_eq("s_inrst_vs",   32'(s_vsync), 1);
    check_eq("s_inrst_disp", 32'(s_display_on), 0);
    check_eq("s_inrst_ls",   32'(s_line_start), 0);
    check_eq("s_inrst_fs",   32'(s_frame_start), 0);
    step();
    rst_s = 1'b0; settle();
    check_eq("s_post_rst_h",  32'(s_hpos), 0);
    check_eq("s_post_rst_v",  32'(s_vpos), 0);
    check_eq("s_post_rst_fs", 32'(s_frame_start), 1);
`ifdef VGA_FRAME_CNT_EN
    check_eq("s_fcnt_rst",    32'(s_frame_cnt), 0);
`endif

    repeat (159) step();
    check_eq("s_last_h", 32'(s_hpos), 15);
    check_eq("s_last_v", 32'(s_vpos), 9);
    ena_s = 1'b0; settle();
    for (int i = 0; i < 20; i++) begin
      check_eq("s_stall", 32'({s_hpos, s_vpos, s_line_start, s_frame_start}),
               32'({10'd15, 10'd9, 2'b00}));
      step();
    end
    ena_s = 1'b1; settle();
    check_eq("s_unstall_ls", 32'(s_line_start), 0);
    step();
    check_eq("s_unstall_h",  32'(s_hpos), 0);
    check_eq("s_unstall_v",  32'(s_vpos), 0);
    check_eq("s_unstall_fs", 32'(s_frame_start), 1);
`ifdef VGA_FRAME_CNT_EN
    check_eq("s_fcnt_after_stall", 32'(s_frame_cnt), 1);
    repeat (254*160) step();
    check_eq("s_fcnt_255", 32'(s_frame_cnt), 255);
    repeat (160) step();
    check_eq("s_fcnt_wrap", 32'(s_frame_cnt), 0);
    check_eq("s_fcnt_h",    32'(s_hpos), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
